// File: rtl/riscv_pkg.sv
// Shared types for the memory port arbiter: read-owner tag and LSU access size.
package riscv_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } mem_owner_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } ls_size_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_be_gen.sv
// LSU lane steering: byte enables, lane-replicated store data and misalignment flag.
module mem_arb_be_gen
  import riscv_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be         = 4'b0011 << i_off;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      SZ_W: begin
        o_be         = BE_FULL;
        o_wdata      = i_wdata;
        o_misaligned = |i_off;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between fetch and LSU, LSU priority by default.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT denied cycles.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MEM_SIZE     = 2048,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        if_req_i,
  input  logic [XLEN-1:0]             if_addr_i,
  output logic                        if_gnt_o,
  output logic                        if_rvalid_o,
  output logic [XLEN-1:0]             if_rdata_o,
  input  logic                        ls_req_i,
  input  logic                        ls_we_i,
  input  logic [1:0]                  ls_size_i,
  input  logic [XLEN-1:0]             ls_addr_i,
  input  logic [XLEN-1:0]             ls_wdata_i,
  output logic                        ls_gnt_o,
  output logic                        ls_err_o,
  output logic                        ls_rvalid_o,
  output logic [XLEN-1:0]             ls_rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
  output logic [XLEN-1:0]             mem_wdata_o,
  input  logic [XLEN-1:0]             mem_rdata_i
);

  localparam int AW = $clog2(MEM_SIZE);

  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_mis;
  logic            w_blk;
  logic            w_force;
  logic            w_ls_take;
  logic            w_ls_err;
  logic            w_if_take;
  logic            r_rst_d;
  mem_owner_e      r_owner;

  mem_arb_be_gen u_be_gen (
    .i_size       (ls_size_i),
    .i_off        (ls_addr_i[1:0]),
    .i_wdata      (ls_wdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis)
  );

  // Grants stay off during reset and for the first cycle after it.
  assign w_blk = rst_i | r_rst_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve;

  assign w_force = if_req_i & (r_starve == CW'(STARVE_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i || !if_req_i || w_if_take) begin
      r_starve <= '0;
    end else if (r_starve != CW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + CW'(1);
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign w_force = 1'b0;
`endif

  // A rejected LSU request is consumed without the port, so fetch may use it.
  assign w_ls_take = ~w_blk & ls_req_i & ~w_mis & ~w_force;
  assign w_ls_err  = ~w_blk & ls_req_i & w_mis;
  assign w_if_take = ~w_blk & if_req_i & ~w_ls_take;

  assign if_gnt_o = w_if_take;
  assign ls_gnt_o = w_ls_take | w_ls_err;
  assign ls_err_o = w_ls_err;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_ls_take) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_be_o    = w_be;
      mem_addr_o  = ls_addr_i[AW+1:2];
      mem_wdata_o = ls_we_i ? w_wdata : '0;
    end else if (w_if_take) begin
      mem_en_o   = 1'b1;
      mem_be_o   = BE_FULL;
      mem_addr_o = if_addr_i[AW+1:2];
    end
  end

  always_ff @(posedge clk_i) begin
    r_rst_d <= rst_i;
    if (rst_i) begin
      r_owner <= OWN_NONE;
    end else if (w_ls_take && !ls_we_i) begin
      r_owner <= OWN_LS;
    end else if (w_if_take) begin
      r_owner <= OWN_IF;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign if_rvalid_o = (r_owner == OWN_IF) & ~rst_i;
  assign ls_rvalid_o = (r_owner == OWN_LS) & ~rst_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

  logic w_unused;
  assign w_unused = &{1'b0, if_addr_i[1:0], if_addr_i[XLEN-1:AW+2], ls_addr_i[XLEN-1:AW+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, directed sequences, vector table, random traffic.
module tb_mem_port_arbiter;

  localparam int XLEN         = 32;
  localparam int MEM_SIZE     = 2048;
  localparam int STARVE_LIMIT = 4;
  localparam int AW           = 11;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            if_req_i;
  logic [31:0]     if_addr_i;
  logic            if_gnt_o, if_rvalid_o;
  logic [31:0]     if_rdata_o;
  logic            ls_req_i, ls_we_i;
  logic [1:0]      ls_size_i;
  logic [31:0]     ls_addr_i, ls_wdata_i;
  logic            ls_gnt_o, ls_err_o, ls_rvalid_o;
  logic [31:0]     ls_rdata_o;
  logic            mem_en_o, mem_we_o;
  logic [3:0]      mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic [31:0]     mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_err_o(ls_err_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // SRAM attached to the port; word i starts out holding i.
  logic [31:0] sram [MEM_SIZE];
  bit          init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < MEM_SIZE; i++) sram[i] <= 32'(i);
      init_done <= 1'b1;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference model state
  logic [31:0] gold [MEM_SIZE];
  logic [32:0] exp_q[$];
  bit          m_rst_d = 1'b1;
  int          m_starve = 0;
  bit          m_lgnt, m_ignt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [32:0] e;
    bit has, blk, ill, force_f, lmem, lerr, ignt;
    int unsigned off, lidx, iidx;
    logic [3:0] ebe;
    logic [31:0] ewd;
    has = 1'b0;
    e   = '0;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      has = 1'b1;
    end
    if (rst_i) has = 1'b0;
    chk("if_rvalid", 32'(if_rvalid_o), 32'(has && !e[32]));
    chk("ls_rvalid", 32'(ls_rvalid_o), 32'(has && e[32]));
    chk("if_rdata", if_rdata_o, (has && !e[32]) ? e[31:0] : 32'h0);
    chk("ls_rdata", ls_rdata_o, (has && e[32]) ? e[31:0] : 32'h0);

    blk     = rst_i || m_rst_d;
    off     = ls_addr_i % 4;
    ill     = (ls_size_i == 2'd3) || (ls_size_i == 2'd1 && (off % 2) != 0) ||
              (ls_size_i == 2'd2 && off != 0);
    force_f = GUARD && if_req_i && (m_starve == STARVE_LIMIT);
    lmem    = !blk && ls_req_i && !ill && !force_f;
    lerr    = !blk && ls_req_i && ill;
    ignt    = !blk && if_req_i && !lmem;
    lidx    = (ls_addr_i / 4) % MEM_SIZE;
    iidx    = (if_addr_i / 4) % MEM_SIZE;
    case (ls_size_i)
      2'd0:    begin ebe = 4'(1 << off); ewd = 32'(ls_wdata_i[7:0]) * 32'h01010101; end
      2'd1:    begin ebe = 4'(3 << off); ewd = 32'(ls_wdata_i[15:0]) * 32'h00010001; end
      default: begin ebe = 4'hF;         ewd = ls_wdata_i; end
    endcase

    chk("ls_gnt", 32'(ls_gnt_o), 32'(lmem || lerr));
    chk("ls_err", 32'(ls_err_o), 32'(lerr));
    chk("if_gnt", 32'(if_gnt_o), 32'(ignt));
    chk("mem_en", 32'(mem_en_o), 32'(lmem || ignt));
    chk("mem_we", 32'(mem_we_o), 32'(lmem && ls_we_i));
    chk("mem_be", 32'(mem_be_o), lmem ? 32'(ebe) : (ignt ? 32'hF : 32'h0));
    chk("mem_addr", 32'(mem_addr_o), lmem ? lidx : (ignt ? iidx : 32'h0));
    chk("mem_wdata", mem_wdata_o, (lmem && ls_we_i) ? ewd : 32'h0);

    if (lmem && ls_we_i) begin
      for (int b = 0; b < 4; b++)
        if (ebe[b]) gold[lidx][8*b +: 8] = ewd[8*b +: 8];
    end
    if (lmem && !ls_we_i) exp_q.push_back({1'b1, gold[lidx]});
    if (ignt) exp_q.push_back({1'b0, gold[iidx]});
    if (rst_i || !if_req_i || ignt) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    m_rst_d = rst_i;
    m_lgnt  = lmem || lerr;
    m_ignt  = ignt;
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  task automatic idle();
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    ls_we_i  = 1'b0;
  endtask

  task automatic set_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    ls_req_i   = 1'b1;
    ls_we_i    = we;
    ls_size_i  = size;
    ls_addr_i  = addr;
    ls_wdata_i = wdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        e_lgnt, e_err, e_ignt, e_en;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [10:0] e_addr;
  } vec_t;

  vec_t        tbl[9];
  logic [9:0]  pattern;
  logic [9:0]  exp_pat;
  bit          lg, ig;

  initial begin
    tbl[0] = '{1'b1, 2'd0, 32'h103,  32'hAB,       1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'hABABABAB, 11'h40};
    tbl[1] = '{1'b0, 2'd2, 32'h100,  32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        11'h40};
    tbl[2] = '{1'b1, 2'd1, 32'h101,  32'h5555,     1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0,        11'h8};
    tbl[3] = '{1'b1, 2'd1, 32'h102,  32'h1234CDEF, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hCDEFCDEF, 11'h40};
    tbl[4] = '{1'b1, 2'd2, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 11'h1};
    tbl[5] = '{1'b0, 2'd0, 32'h2001, 32'h0,        1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0,        11'h0};
    tbl[6] = '{1'b0, 2'd3, 32'h10,   32'h0,        1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        11'h0};
    tbl[7] = '{1'b0, 2'd2, 32'h6,    32'h0,        1'b1, 32'h7,  1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0,        11'h1};
    tbl[8] = '{1'b1, 2'd0, 32'h7FFD, 32'h5A,       1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h5A5A5A5A, 11'h7FF};

    for (int i = 0; i < MEM_SIZE; i++) gold[i] = 32'(i);
    rst_i = 1'b1;
    if_addr_i = 32'h0;
    ls_size_i = 2'd2;
    ls_addr_i = 32'h0;
    ls_wdata_i = 32'h0;
    idle();

    // Reset with both requesters active, then the blocked first cycle after it
    if_req_i = 1'b1;
    set_ls(1'b0, 2'd2, 32'h0, 32'h0);
    repeat (3) begin
      half();
      chk("rst_gnt", 32'({ls_gnt_o, if_gnt_o, ls_err_o}), 32'h0);
      chk("rst_mem_en", 32'(mem_en_o), 32'h0);
      fin();
    end
    rst_i = 1'b0;
    half();
    chk("post_rst_gnt", 32'({ls_gnt_o, if_gnt_o}), 32'h0);
    fin();
    idle();
    tick();

    // Back-to-back fetches of words 0,1,2
    for (int k = 0; k < 3; k++) begin
      if_req_i  = 1'b1;
      if_addr_i = 32'(4 * k);
      half();
      chk("fetch_gnt", 32'(if_gnt_o), 32'h1);
      if (k > 0) chk("fetch_rdata", if_rdata_o, 32'(k - 1));
      fin();
    end
    idle();
    half();
    chk("fetch_rdata", if_rdata_o, 32'h2);
    fin();

    // SB 0xAB to 0x103 then LW 0x100
    set_ls(1'b1, 2'd0, 32'h103, 32'hAB);
    tick();
    set_ls(1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    idle();
    half();
    chk("sb_lw_rdata", ls_rdata_o, 32'hAB000040);
    fin();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      set_ls(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      if_req_i  = tbl[i].if_req;
      if_addr_i = tbl[i].if_addr;
      half();
      chk("tbl_ls_gnt", 32'(ls_gnt_o), 32'(tbl[i].e_lgnt));
      chk("tbl_ls_err", 32'(ls_err_o), 32'(tbl[i].e_err));
      chk("tbl_if_gnt", 32'(if_gnt_o), 32'(tbl[i].e_ignt));
      chk("tbl_mem_en", 32'(mem_en_o), 32'(tbl[i].e_en));
      chk("tbl_mem_be", 32'(mem_be_o), 32'(tbl[i].e_be));
      chk("tbl_mem_wdata", mem_wdata_o, tbl[i].e_wd);
      chk("tbl_mem_addr", 32'(mem_addr_o), 32'(tbl[i].e_addr));
      fin();
    end
    idle();
    tick();

    // Ten cycles of continuous contention
    set_ls(1'b0, 2'd2, 32'h200, 32'h0);
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    for (int c = 0; c < 10; c++) begin
      half();
      pattern[c] = if_gnt_o;
      fin();
    end
    exp_pat = GUARD ? 10'b10_0001_0000 : 10'b0;
    chk("starve_pattern", 32'(pattern), 32'(exp_pat));
    idle();
    tick();

    // Reset arriving while a granted load's data is due
    set_ls(1'b0, 2'd2, 32'h100, 32'h0);
    half();
    chk("rst_load_gnt", 32'(ls_gnt_o), 32'h1);
    fin();
    rst_i = 1'b1;
    half();
    chk("rst_drop_rvalid", 32'(ls_rvalid_o), 32'h0);
    chk("rst_ls_gnt", 32'(ls_gnt_o), 32'h0);
    fin();
    rst_i = 1'b0;
    idle();
    if_req_i  = 1'b1;
    if_addr_i = 32'h8;
    tick();
    half();
    chk("post_rst_fetch", 32'(if_gnt_o), 32'h1);
    fin();
    idle();
    half();
    chk("post_rst_rdata", if_rdata_o, 32'h2);
    fin();

    // Random traffic; each requester holds its request until granted
    for (int n = 0; n < 400; n++) begin
      if (!ls_req_i && $urandom_range(0, 1) == 1)
        set_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               32'h300 + 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 1)) << 13),
               $urandom);
      if (!if_req_i && $urandom_range(0, 2) != 0) begin
        if_req_i  = 1'b1;
        if_addr_i = 32'($urandom_range(0, 1023)) + 32'h300;
      end
      half();
      lg = m_lgnt;
      ig = m_ignt;
      fin();
      if (lg) ls_req_i = 1'b0;
      if (ig) if_req_i = 1'b0;
    end
    idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
